uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver that sits directly upstream of the cpu on mother_board. It oversamples the `uart_rx` pin, deserializes 8N1 frames (LSB first), and presents each completed byte on a holding register with a level interrupt request. The cpu consumes the request through its `ack` output.

## Interface
Parameters:
- WAIT, default 8: clock cycles per bit. Must be even and ≥ 4. Uses the same value as the mother_board `WAIT` parameter.

Ports:
- clk  input  1  system clock; one clock domain, all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- ack  input  1  one-cycle pulse from cpu: byte consumed
- rx_data  output  8  last received byte
- intr  output  1  byte-available request, level
- overrun  output  1  sticky: a byte completed while intr was still pending
- frame_err  output  1  sticky: stop bit sampled as 0

## Operation
- Synchronizer: two flops on uart_rx (ff1, ff2). The FSM uses only ff2 (rx_s). Both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP. Counters: cnt (clog2(WAIT) bits) and bit index idx (3 bits).
- IDLE: if rx_s == 0, go to START with cnt = 0.
- START: cnt increments each cycle. At cnt == WAIT/2-1:
  - rx_s == 0: go to DATA with cnt = 0, idx = 0.
  - rx_s == 1: glitch; go to IDLE, no side effects.
- DATA: at cnt == WAIT-1, shift rx_s into shift[idx] (LSB first), set cnt = 0, idx++. After idx 7 is captured, go to STOP.
- STOP: at cnt == WAIT-1, sample rx_s:
  - rx_s == 1: rx_data <= shift. intr <= 1. If intr was already 1 and ack is not asserted this cycle, overrun <= 1.
  - rx_s == 0: frame_err <= 1. rx_data and intr unchanged.
  - In both cases go to IDLE. The next start bit is detectable from the following cycle onward.
- ack: intr <= 0, overrun <= 0, frame_err <= 0. If ack coincides with a valid stop-sample edge, the new byte wins: intr stays 1, rx_data updates, and overrun is not set.
- ack while intr == 0 has no effect except clearing the sticky flags.
- Reset (any state, including mid-frame): FSM to IDLE; cnt, idx, shift, rx_data cleared to 0; intr, overrun, frame_err cleared to 0; ff1/ff2 set to 1. A frame in flight is discarded.

## Timing
- E0 is the first rising edge at which ff1 samples uart_rx == 0.
- rx_s goes low after E0+1. The START transition occurs at edge E0+2.
- Data bit i (0..7) is captured at edge E0+2+WAIT/2+(i+1)·WAIT, i.e. mid-bit.
- The stop sample, rx_data update and intr rise occur at edge E0+2+WAIT/2+9·WAIT. For WAIT=8 this is E0+78.
- ack → intr low after the same edge that samples ack (1-cycle latency).
- Reset values: rx_data=0x00, intr=0, overrun=0, frame_err=0.
- No back-pressure: a new frame is always received. rx_data is overwritten even while intr is pending.
- Tolerates up to ±WAIT/2-1 cycles of cumulative bit-edge skew per frame.

## Test plan
- WAIT=8, send 0x55 (start, 1,0,1,0,1,0,1,0, stop) → intr rises at E0+78, rx_data=0x55, overrun=0, frame_err=0. Then pulse ack → intr=0 on the next cycle.
- Glitch: uart_rx low for 2 cycles then high → FSM returns to IDLE, intr stays 0, rx_data unchanged. A following 0xA3 frame is received correctly.
- Framing error: send 0x3C with stop bit 0 → frame_err=1, intr=0, rx_data unchanged. ack → frame_err=0.
- Back-to-back 0x12 then 0x34 with no ack → rx_data=0x34, intr=1, overrun=1. ack → intr=0, overrun=0.
- ack asserted exactly on the stop-sample edge of a second byte 0xF0 → intr=1, rx_data=0xF0, overrun=0.
- reset asserted mid-DATA of 0xFF → all outputs 0 the next cycle. A subsequent 0x81 frame → rx_data=0x81, intr=1.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver with a byte holding register,
// a level interrupt request towards the cpu, and sticky overrun/framing flags.
// The serial line is brought into the clk domain through a two-flop synchronizer.
// The receive FSM finds the middle of the start bit and then samples one
// bit every WAIT cycles.
module uart_receiver #(
    parameter int WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       ack,
    output logic [7:0] rx_data,
    output logic       intr,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    // Counter values at which the FSM samples: middle of the start bit, and one full bit later.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(WAIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    logic ff1;
    logic ff2;
    logic rx_s;

    logic stop_edge;
    logic stop_ok;
    logic stop_bad;

    // Two-flop synchronizer on the asynchronous serial line. Both flops reset to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
        end else begin
            ff1 <= uart_rx;
            ff2 <= ff1;
        end
    end

    assign rx_s = ff2;

    // Stop-bit sampling edge and its outcome; these drive the host-facing flags.
    assign stop_edge = (state == STOP) && (cnt == FULL_M1);
    assign stop_ok   = stop_edge && rx_s;
    assign stop_bad  = stop_edge && !rx_s;

    // Receive FSM: start-bit qualification, LSB-first data shifting and stop-bit checking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            // Line still low at mid start bit: a real frame.
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        shift[idx] <= rx_s;
                        cnt        <= '0;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == FULL_M1) begin
                        // Back to IDLE right away so the next start bit is seen on the following cycle.
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Host-facing registers. A valid stop sample takes priority over an ack on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= 8'h00;
            intr      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ack) begin
                intr      <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (stop_ok) begin
                rx_data <= shift;
                intr    <= 1'b1;
                // Only an unconsumed previous byte counts as lost. An ack on this
                // same edge means the cpu took it.
                if (intr && !ack) begin
                    overrun <= 1'b1;
                end
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver (WAIT=8). Expected values
// are written out by hand for each scenario.
module tb_uart_receiver;

    localparam int WAIT = 8;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic       ack;
    logic [7:0] rx_data;
    logic       intr;
    logic       overrun;
    logic       frame_err;

    int n_total;
    int n_pass;
    int cyc;
    int e0;
    int rise_at;
    logic intr_q;

    uart_receiver #(.WAIT(WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .ack       (ack),
        .rx_data   (rx_data),
        .intr      (intr),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to time the interrupt rise
    always @(posedge clk) cyc = cyc + 1;

    // Record the edge count at which intr goes high
    always @(negedge clk) begin
        if (intr && !intr_q) rise_at = cyc;
        intr_q = intr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; the next rising edge is E0.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        e0 = cyc + 1;
        uart_rx = 1'b0;
        repeat (WAIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (WAIT) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (WAIT) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        cyc     = 0;
        e0      = 0;
        rise_at = -1;
        intr_q  = 1'b0;
        reset   = 1'b1;
        uart_rx = 1'b1;
        ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Reset state
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_intr", 32'(intr), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // 0x55: intr rises exactly at E0+78
        send_frame(8'h55, 1'b1);
        check("t55_rise_edge", 32'(rise_at - e0), 32'd78);
        check("t55_rx_data", 32'(rx_data), 32'h55);
        check("t55_intr", 32'(intr), 32'h1);
        check("t55_overrun", 32'(overrun), 32'h0);
        check("t55_frame_err", 32'(frame_err), 32'h0);
        pulse_ack();
        check("t55_ack_intr", 32'(intr), 32'h0);
        idle(4);

        // Glitch: two cycles low, then high again
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(20);
        check("glitch_intr", 32'(intr), 32'h0);
        check("glitch_rx_data", 32'(rx_data), 32'h55);
        send_frame(8'hA3, 1'b1);
        check("a3_rx_data", 32'(rx_data), 32'hA3);
        check("a3_intr", 32'(intr), 32'h1);
        pulse_ack();
        idle(4);

        // Framing error: stop bit low
        send_frame(8'h3C, 1'b0);
        idle(12);
        check("ferr_frame_err", 32'(frame_err), 32'h1);
        check("ferr_intr", 32'(intr), 32'h0);
        check("ferr_rx_data", 32'(rx_data), 32'hA3);
        pulse_ack();
        check("ferr_ack_clear", 32'(frame_err), 32'h0);
        idle(4);

        // Back-to-back without ack
        send_frame(8'h12, 1'b1);
        check("b2b_first", 32'(rx_data), 32'h12);
        check("b2b_first_ovr", 32'(overrun), 32'h0);
        send_frame(8'h34, 1'b1);
        check("b2b_rx_data", 32'(rx_data), 32'h34);
        check("b2b_intr", 32'(intr), 32'h1);
        check("b2b_overrun", 32'(overrun), 32'h1);
        pulse_ack();
        check("b2b_ack_intr", 32'(intr), 32'h0);
        check("b2b_ack_overrun", 32'(overrun), 32'h0);
        idle(4);

        // ack coincides with the stop-sample edge of 0xF0
        send_frame(8'h0F, 1'b1);
        check("coin_pending", 32'(intr), 32'h1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1;
                ack = 1'b1;
                @(posedge clk);
                #1;
                ack = 1'b0;
            end
        join
        check("coin_intr", 32'(intr), 32'h1);
        check("coin_rx_data", 32'(rx_data), 32'hF0);
        check("coin_overrun", 32'(overrun), 32'h0);
        idle(4);

        // Reset mid-DATA of 0xFF, while a byte is still pending
        check("mid_pre_intr", 32'(intr), 32'h1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check("mid_rst_rx_data", 32'(rx_data), 32'h00);
                check("mid_rst_intr", 32'(intr), 32'h0);
                check("mid_rst_overrun", 32'(overrun), 32'h0);
                check("mid_rst_frame_err", 32'(frame_err), 32'h0);
            end
        join
        idle(4);
        check("mid_discard_intr", 32'(intr), 32'h0);
        send_frame(8'h81, 1'b1);
        check("post_rst_rx_data", 32'(rx_data), 32'h81);
        check("post_rst_intr", 32'(intr), 32'h1);
        check("post_rst_ferr", 32'(frame_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
